// File: rtl/bcd_timer_ctrl.sv
// Two-digit packed-BCD down-counter controller: load, prescaled BCD decrement, hold/resume, clear.
// Latency: preset visible on Q at the loading edge; one BCD step every PRESCALE RUN cycles.
// No backpressure: START/STOP/CLEAR are level commands sampled every edge; ERR/DONE are single-cycle pulses.
module bcd_timer_ctrl #(
   parameter int unsigned PRESCALE = 4,
   parameter logic [7:0]  MAX_BCD  = 8'h59
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       STOP,
   input  logic       CLEAR,
   input  logic [7:0] PRESET,
   output logic [7:0] Q,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   // Prescaler width; a single bit is kept even when PRESCALE is 1.
   localparam int unsigned    PCW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t         state;
   logic [PCW-1:0] pc;

   logic       preset_ok;
   logic [7:0] q_dec;
   logic       tick;
   logic       last_step;

   // A preset is loadable when both nibbles are decimal digits, it does not
   // exceed the configured maximum, and it is non-zero (zero would finish instantly).
   always_comb begin
      preset_ok = (PRESET[7:4] <= 4'd9) &&
                  (PRESET[3:0] <= 4'd9) &&
                  (PRESET <= MAX_BCD)   &&
                  (PRESET != 8'h00);
   end

   // One BCD count down with borrow from the tens digit; Q is never 00 in RUN,
   // so the tens digit never underflows here.
   always_comb begin
      q_dec = Q;
      if (Q[3:0] == 4'd0) begin
         q_dec[3:0] = 4'd9;
         q_dec[7:4] = Q[7:4] - 4'd1;
      end else begin
         q_dec[3:0] = Q[3:0] - 4'd1;
      end
   end

   // Prescaler terminal count and the step that lands on 00.
   always_comb begin
      tick      = (pc == PC_LAST);
      last_step = (Q == 8'h01);
   end

   // Controller state, prescaler and all registered outputs.
   // Priority on every edge is CLEAR, then STOP, then START.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= S_IDLE;
         pc    <= '0;
         Q     <= 8'h00;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
      end else if (CLEAR) begin
         state <= S_IDLE;
         pc    <= '0;
         Q     <= 8'h00;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         // Pulses default low; only the branches below raise them for one cycle.
         DONE <= 1'b0;
         ERR  <= 1'b0;
         case (state)
            S_IDLE: begin
               // STOP masks START entirely: no load and no rejection pulse.
               if (START && !STOP) begin
                  if (preset_ok) begin
                     Q     <= PRESET;
                     pc    <= '0;
                     state <= S_RUN;
                     BUSY  <= 1'b1;
                  end else begin
                     ERR <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (STOP) begin
                  // Q and pc freeze so the partial tick survives the pause.
                  state <= S_HOLD;
                  BUSY  <= 1'b1;
               end else if (tick) begin
                  pc <= '0;
                  if (Q != 8'h00) begin
                     Q <= q_dec;
                  end
                  if (last_step) begin
                     state <= S_FIN;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                  end
               end else begin
                  pc <= pc + PCW'(1);
               end
            end

            S_HOLD: begin
               // The resume edge itself does not advance pc.
               if (START && !STOP) begin
                  state <= S_RUN;
               end
               BUSY <= 1'b1;
            end

            S_FIN: begin
               // Single-cycle completion state; START here is ignored.
               state <= S_IDLE;
               BUSY  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               pc    <= '0;
               Q     <= 8'h00;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: vector table, directed timing sequences,
// and a randomized run against a decimal-integer reference model.
// Two instances: PRESCALE=4 for most checks, PRESCALE=1 for the fast-count case.
module tb_bcd_timer_ctrl;

   localparam int PRE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start, stop, clear;
   logic [7:0] preset;
   logic [7:0] q;
   logic       busy, done, err;

   logic       start1, stop1, clear1;
   logic [7:0] preset1;
   logic [7:0] q1;
   logic       busy1, done1, err1;

   int errors = 0;
   int checks = 0;

   bcd_timer_ctrl #(.PRESCALE(PRE), .MAX_BCD(8'h59)) dut (
      .CLK(clk), .RESET(rst_n), .START(start), .STOP(stop), .CLEAR(clear),
      .PRESET(preset), .Q(q), .BUSY(busy), .DONE(done), .ERR(err)
   );

   bcd_timer_ctrl #(.PRESCALE(1), .MAX_BCD(8'h59)) dut1 (
      .CLK(clk), .RESET(rst_n), .START(start1), .STOP(stop1), .CLEAR(clear1),
      .PRESET(preset1), .Q(q1), .BUSY(busy1), .DONE(done1), .ERR(err1)
   );

   typedef struct {
      logic       start;
      logic       stop;
      logic       clear;
      logic [7:0] preset;
      logic [7:0] q;
      logic       busy;
      logic       done;
      logic       err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic s, input logic p, input logic c, input logic [7:0] pr,
                               input logic [7:0] eq, input logic eb, input logic ed, input logic ee);
      vec_t v;
      v.start = s; v.stop = p; v.clear = c; v.preset = pr;
      v.q = eq; v.busy = eb; v.done = ed; v.err = ee;
      return v;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic [7:0] eq, input logic eb,
                          input logic ed, input logic ee);
      chk({name, ".q"},    32'(q),    32'(eq));
      chk({name, ".busy"}, 32'(busy), 32'(eb));
      chk({name, ".done"}, 32'(done), 32'(ed));
      chk({name, ".err"},  32'(err),  32'(ee));
   endtask

   // Apply inputs, let one rising edge sample them, then settle before checking.
   task automatic tick(input logic s, input logic p, input logic c, input logic [7:0] pr);
      start = s; stop = p; clear = c; preset = pr;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (decimal value + elapsed ticks) ----------------
   int m_val;
   int m_phase;
   bit m_run, m_hold, m_fin;
   bit m_done, m_err;

   function automatic bit preset_valid(input logic [7:0] p);
      int t, u, d;
      t = int'(p) / 16;
      u = int'(p) % 16;
      d = t * 10 + u;
      return (t <= 9) && (u <= 9) && (d <= 59) && (d != 0);
   endfunction

   task automatic model_step(input logic s, input logic p, input logic c, input logic [7:0] pr);
      m_done = 0;
      m_err  = 0;
      if (c) begin
         m_val = 0; m_phase = 0; m_run = 0; m_hold = 0; m_fin = 0;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (m_run) begin
         if (p) begin
            m_run = 0; m_hold = 1;
         end else begin
            m_phase = m_phase + 1;
            if (m_phase == PRE) begin
               m_phase = 0;
               m_val   = m_val - 1;
               if (m_val == 0) begin
                  m_run = 0; m_fin = 1; m_done = 1;
               end
            end
         end
      end else if (m_hold) begin
         if (s && !p) begin
            m_hold = 0; m_run = 1;
         end
      end else if (s && !p) begin
         if (preset_valid(pr)) begin
            m_val = (int'(pr) / 16) * 10 + int'(pr) % 16;
            m_phase = 0;
            m_run = 1;
         end else begin
            m_err = 1;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 0; stop = 0; clear = 0; preset = 8'h00;
      start1 = 0; stop1 = 0; clear1 = 0; preset1 = 8'h00;

      // Reset state, visible without any clock edge.
      #1;
      chk_out("reset", 8'h00, 0, 0, 0);
      #21;
      rst_n = 1'b1;

      // ---------------- vector table (PRESCALE=4, one edge per entry) ----------------
      vq.push_back(mk(0,0,0,8'h00, 8'h00,0,0,0));  // idle
      vq.push_back(mk(1,0,0,8'h1A, 8'h00,0,0,1));  // bad units nibble
      vq.push_back(mk(0,0,0,8'h00, 8'h00,0,0,0));  // ERR drops
      vq.push_back(mk(1,0,0,8'h60, 8'h00,0,0,1));  // above MAX_BCD
      vq.push_back(mk(1,0,0,8'h00, 8'h00,0,0,1));  // zero preset
      vq.push_back(mk(1,1,0,8'h59, 8'h00,0,0,0));  // STOP masks START
      vq.push_back(mk(1,0,1,8'h03, 8'h00,0,0,0));  // CLEAR beats START
      vq.push_back(mk(1,0,0,8'h03, 8'h03,1,0,0));  // load
      vq.push_back(mk(1,0,0,8'h07, 8'h03,1,0,0));  // START ignored in RUN
      vq.push_back(mk(0,0,0,8'h00, 8'h03,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h03,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h02,1,0,0));  // first step
      vq.push_back(mk(1,1,0,8'h00, 8'h02,1,0,0));  // STOP over START -> HOLD
      vq.push_back(mk(0,1,0,8'h00, 8'h02,1,0,0));  // STOP in HOLD ignored
      vq.push_back(mk(1,0,0,8'h00, 8'h02,1,0,0));  // resume
      vq.push_back(mk(0,0,0,8'h00, 8'h02,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h02,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h02,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h01,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h01,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h01,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h01,1,0,0));
      vq.push_back(mk(0,0,0,8'h00, 8'h00,0,1,0));  // completion
      vq.push_back(mk(1,0,0,8'h05, 8'h00,0,0,0));  // START in FIN ignored
      vq.push_back(mk(1,0,0,8'h02, 8'h02,1,0,0));  // load
      vq.push_back(mk(0,0,1,8'h00, 8'h00,0,0,0));  // CLEAR in RUN
      vq.push_back(mk(1,0,0,8'h02, 8'h02,1,0,0));  // load
      vq.push_back(mk(0,1,0,8'h00, 8'h02,1,0,0));  // HOLD
      vq.push_back(mk(0,0,1,8'h00, 8'h00,0,0,0));  // CLEAR in HOLD
      foreach (vq[i]) begin
         tick(vq[i].start, vq[i].stop, vq[i].clear, vq[i].preset);
         chk_out($sformatf("vec%0d", i), vq[i].q, vq[i].busy, vq[i].done, vq[i].err);
      end

      // ---------------- borrow and completion: 12 at PRESCALE=4 ----------------
      tick(1, 0, 0, 8'h12);
      chk_out("brw.k", 8'h12, 1, 0, 0);
      for (int i = 1; i <= 49; i++) begin
         tick(0, 0, 0, 8'h00);
         chk($sformatf("brw.q@%0d", i), 32'(q), 32'(to_bcd(i <= 48 ? 12 - i / 4 : 0)));
         if (i >= 47) begin
            chk($sformatf("brw.done@%0d", i), 32'(done), 32'(i == 48));
            chk($sformatf("brw.busy@%0d", i), 32'(busy), 32'(i < 48));
         end
      end

      // ---------------- pause/resume: 05, STOP at k+6, START at k+15 ----------------
      tick(1, 0, 0, 8'h05);
      for (int i = 1; i <= 31; i++) begin
         int ev;
         tick(i == 15, i == 6, 0, 8'h00);
         ev = (i < 4) ? 5 : (i < 18) ? 4 : (i < 22) ? 3 : (i < 26) ? 2 : (i < 30) ? 1 : 0;
         chk_out($sformatf("pause@%0d", i), to_bcd(ev), i < 30, i == 30, 0);
      end

      // ---------------- asynchronous reset mid-count ----------------
      tick(1, 0, 0, 8'h30);
      for (int i = 1; i <= 9; i++) tick(0, 0, 0, 8'h00);
      chk_out("arst.pre", 8'h28, 1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk_out("arst.now", 8'h00, 0, 0, 0);
      #2;
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(0, 0, 0, 8'h00);
         chk_out($sformatf("arst.after%0d", i), 8'h00, 0, 0, 0);
      end

      // ---------------- PRESCALE=1 instance: 10 counts down every edge ----------------
      start1 = 1; preset1 = 8'h10;
      @(posedge clk); #1;
      chk("p1.load", 32'(q1), 32'(8'h10));
      start1 = 0; preset1 = 8'h00;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         chk($sformatf("p1.q@%0d", i), 32'(q1), 32'(to_bcd(i <= 10 ? 10 - i : 0)));
         chk($sformatf("p1.done@%0d", i), 32'(done1), 32'(i == 10));
         chk($sformatf("p1.busy@%0d", i), 32'(busy1), 32'(i < 10));
         chk($sformatf("p1.err@%0d", i), 32'(err1), 32'(0));
      end

      // ---------------- randomized run against the reference model ----------------
      tick(0, 0, 1, 8'h00);
      model_step(0, 0, 1, 8'h00);
      for (int i = 0; i < 400; i++) begin
         logic       rs, rp, rc;
         logic [7:0] rpr;
         int         sel;
         rs  = ($urandom_range(0, 3) == 0);
         rp  = ($urandom_range(0, 9) == 0);
         rc  = ($urandom_range(0, 59) == 0);
         sel = $urandom_range(0, 3);
         if (sel == 0)      rpr = 8'($urandom_range(0, 255));
         else if (sel == 1) rpr = to_bcd($urandom_range(0, 70));
         else               rpr = to_bcd($urandom_range(1, 5));
         tick(rs, rp, rc, rpr);
         model_step(rs, rp, rc, rpr);
         chk_out($sformatf("rnd%0d", i), to_bcd(m_val), m_run | m_hold, m_done, m_err);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Sequencing controller for a two-digit packed-BCD count register. It loads a BCD preset on command and decrements it once per prescaled tick, with BCD borrow. It supports stop/resume and clear, and signals completion and bad presets. It sits between the front-panel/command logic and the 8-bit BCD display value Q, and is the only writer of that value.

## Interface
- PRESCALE, 4: clock cycles per count step; legal range 1..256.
- MAX_BCD, 8'h59: largest accepted preset, packed BCD.
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  load preset (in IDLE) or resume (in HOLD); sampled each edge.
- STOP  input  1  pause a running count; sampled each edge.
- CLEAR  input  1  synchronous abort to IDLE with Q=00; highest priority.
- PRESET  input  8  packed BCD preset: [7:4] tens, [3:0] units.
- Q  output  8  current packed-BCD count, registered.
- BUSY  output  1  high in RUN or HOLD, registered.
- DONE  output  1  one-cycle pulse when the count reaches 00, registered.
- ERR  output  1  one-cycle pulse when START is rejected, registered.

## Operation
- States: IDLE, RUN, HOLD, FIN. Internal prescaler PC has width clog2(PRESCALE), minimum 1 bit.
- Input priority per edge: CLEAR, then STOP, then START.
- CLEAR in any state: Q=00, PC=0, state=IDLE, DONE=0, ERR=0.
- IDLE, START=1, STOP=0:
  - A preset is valid when both nibbles are ≤9, PRESET ≤ MAX_BCD, and PRESET ≠ 00.
  - Valid preset: Q=PRESET, PC=0, state=RUN.
  - Invalid preset: ERR=1 for one cycle; Q and state unchanged.
- IDLE, START=1 with STOP=1: no action, no ERR.
- RUN, each edge without STOP:
  - If PC==PRESCALE-1: PC=0 and Q steps down one BCD count. If units==0, then units=9 and tens=tens-1; otherwise units=units-1.
  - Otherwise PC=PC+1.
  - If the step takes Q from 01 to 00: state=FIN and DONE=1.
- RUN, STOP=1: state=HOLD; Q and PC frozen.
- START while in RUN: ignored.
- HOLD, START=1 and STOP=0: state=RUN. PC resumes from its frozen value, so no partial tick is lost.
- STOP while in HOLD: ignored.
- FIN: lasts exactly one cycle; next edge state=IDLE, DONE=0. Q stays 00.
- START during FIN: ignored; no ERR.
- Q never holds a non-BCD nibble. Q never wraps below 00.
- BUSY is derived from the next state and registered with it.

## Timing
- Reset values: Q=8'h00, BUSY=0, DONE=0, ERR=0, state=IDLE, PC=0.
- RESET asserted mid-count returns every output to its reset value immediately, without waiting for a clock edge.
- Load at edge k (START sampled): Q=PRESET and BUSY=1 from edge k.
- First decrement occurs at edge k+PRESCALE.
- For a preset of decimal value N with no pauses:
  - Q reaches 00 at edge k+N·PRESCALE.
  - At that same edge DONE=1 and BUSY=0.
  - DONE=0 at edge k+N·PRESCALE+1.
- Each HOLD cycle adds exactly one cycle to the total.
- ERR goes high at the edge that samples the rejected START and low at the next edge.
- PRESCALE=1: Q decrements on every RUN edge.

## Test plan
- Async reset: with PRESCALE=4, load 8'h30, run 9 cycles, then pull RESET low between edges. Q=00, BUSY=0 and DONE=0 without waiting for an edge. No count after RESET releases until a new START.
- Borrow and completion: PRESCALE=4, START with PRESET=8'h12 at edge k.
  - Q is 12 at k, 11 at k+4, 10 at k+8, 09 at k+12.
  - Q=00 and DONE=1 at k+48; BUSY=0 at k+48.
  - DONE=0 at k+49.
- Rejection:
  - START with PRESET=8'h1A gives ERR=1 for one cycle with Q and BUSY unchanged.
  - Repeat with 8'h60 (exceeds MAX_BCD) and with 8'h00; each gives the same result.
- Pause/resume: PRESCALE=4, start 8'h05 at edge k.
  - STOP at k+6 gives Q=04, frozen for 10 cycles.
  - START resumes; DONE at k+30.
  - START sampled during HOLD gives no ERR.
- Priorities:
  - CLEAR with START in IDLE gives Q=00, state IDLE, no ERR.
  - STOP with START in RUN enters HOLD.
  - CLEAR during HOLD gives Q=00, BUSY=0.
- PRESCALE=1 with PRESET=8'h10: Q runs 10, 09, 08, …, 00 on consecutive edges; DONE 10 cycles after load.
